// File: rtl/norm1_mul_pipe.sv
// norm1_mul_pipe: pipelined signed/unsigned multiplier with an optional
// packet accumulator in the final stage. A beat accepted at edge t reaches
// the output register at edge t+NUM_STAGE. A single ready signal stalls the
// whole pipe whenever the output register holds a result the consumer has
// not taken yet.
module norm1_mul_pipe #(
    parameter int DIN0_WIDTH = 25,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 31,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_signed,
    input  logic                  in_acc,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_ovf
);

    // Full product width and the working width that holds both the full
    // product and the result without loss.
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int MW = (PW > DOUT_WIDTH) ? PW : DOUT_WIDTH;

    // Truncation check: the bits above the result must be a pure sign
    // extension (signed) or all zero (unsigned). Empty when MW==DOUT_WIDTH.
    function automatic logic trunc_ovf(input logic [MW-1:0] p, input logic sgn);
        logic o;
        o = 1'b0;
        for (int i = DOUT_WIDTH; i < MW; i++) begin
            if (sgn ? (p[i] != p[DOUT_WIDTH-1]) : (p[i] == 1'b1)) begin
                o = 1'b1;
            end
        end
        return o;
    endfunction

    // Accumulator overflow: signed uses operand/sum sign rule, unsigned
    // uses the carry out of the modulo add.
    function automatic logic add_ovf(input logic [DOUT_WIDTH-1:0] x,
                                     input logic [DOUT_WIDTH-1:0] y,
                                     input logic [DOUT_WIDTH-1:0] s,
                                     input logic                  carry,
                                     input logic                  sgn);
        logic o;
        if (sgn) begin
            o = (x[DOUT_WIDTH-1] == y[DOUT_WIDTH-1]) &&
                (s[DOUT_WIDTH-1] != x[DOUT_WIDTH-1]);
        end else begin
            o = carry;
        end
        return o;
    endfunction

    logic                  adv;
    logic                  out_valid_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  out_ovf_q;
    logic [DOUT_WIDTH-1:0] accum_q;
    logic                  sticky_q;

    logic [MW-1:0]         a_ext_d;
    logic [MW-1:0]         b_ext_d;
    logic [MW-1:0]         prod_d;
    logic [DOUT_WIDTH-1:0] res_d;
    logic                  ovf_d;

    logic [DOUT_WIDTH-1:0] st_res_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]  st_ovf_q;
    logic [NUM_STAGE-1:0]  st_sgn_q;
    logic [NUM_STAGE-1:0]  st_acc_q;
    logic [NUM_STAGE-1:0]  st_last_q;
    logic [NUM_STAGE-1:0]  st_vld_q;

    logic [DOUT_WIDTH-1:0] fin_res;
    logic                  fin_ovf;
    logic                  fin_sgn;
    logic                  fin_acc;
    logic                  fin_last;
    logic                  fin_vld;
    logic [DOUT_WIDTH-1:0] sum_d;
    logic                  carry_d;
    logic                  pkt_ovf_d;

    // The pipe moves only when the output register is free or being drained.
    assign adv       = ~(out_valid_q & ~out_ready);
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_ovf   = out_ovf_q;

    // Operand extension per mode and the product in the working width.
    always_comb begin
        a_ext_d = {{(MW-DIN0_WIDTH){in_signed & din0[DIN0_WIDTH-1]}}, din0};
        b_ext_d = {{(MW-DIN1_WIDTH){in_signed & din1[DIN1_WIDTH-1]}}, din1};
        prod_d  = a_ext_d * b_ext_d;
        res_d   = prod_d[DOUT_WIDTH-1:0];
        ovf_d   = trunc_ovf(prod_d, in_signed);
    end

    // Stage data registers: loaded from the multiplier at accept, then shifted.
    always_ff @(posedge ap_clk) begin
        if (adv) begin
            st_res_q[0]  <= res_d;
            st_ovf_q[0]  <= ovf_d;
            st_sgn_q[0]  <= in_signed;
            st_acc_q[0]  <= in_acc;
            st_last_q[0] <= in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                st_res_q[i]  <= st_res_q[i-1];
                st_ovf_q[i]  <= st_ovf_q[i-1];
                st_sgn_q[i]  <= st_sgn_q[i-1];
                st_acc_q[i]  <= st_acc_q[i-1];
                st_last_q[i] <= st_last_q[i-1];
            end
        end
    end

    // Stage valids: a beat enters on every advancing edge with in_valid high.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            st_vld_q <= '0;
        end else if (adv) begin
            st_vld_q[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                st_vld_q[i] <= st_vld_q[i-1];
            end
        end
    end

    // Last pipeline stage feeding the accumulate/output stage.
    always_comb begin
        fin_res   = st_res_q[NUM_STAGE-1];
        fin_ovf   = st_ovf_q[NUM_STAGE-1];
        fin_sgn   = st_sgn_q[NUM_STAGE-1];
        fin_acc   = st_acc_q[NUM_STAGE-1];
        fin_last  = st_last_q[NUM_STAGE-1];
        fin_vld   = st_vld_q[NUM_STAGE-1];
        {carry_d, sum_d} = {1'b0, accum_q} + {1'b0, fin_res};
        pkt_ovf_d = sticky_q | fin_ovf |
                    add_ovf(accum_q, fin_res, sum_d, carry_d, fin_sgn);
    end

    // Output register and accumulator: plain beats pass their product,
    // packet beats add into the accumulator and the last one emits it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ovf_q   <= 1'b0;
            accum_q     <= '0;
            sticky_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= 1'b0;
            if (fin_vld) begin
                if (fin_acc) begin
                    if (fin_last) begin
                        dout_q      <= sum_d;
                        out_ovf_q   <= pkt_ovf_d;
                        out_valid_q <= 1'b1;
                        accum_q     <= '0;
                        sticky_q    <= 1'b0;
                    end else begin
                        accum_q  <= sum_d;
                        sticky_q <= pkt_ovf_d;
                    end
                end else begin
                    dout_q      <= fin_res;
                    out_ovf_q   <= fin_ovf;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_norm1_mul_pipe.sv
// Directed bench for norm1_mul_pipe at default parameters.
module tb_norm1_mul_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] din0;
    logic [5:0]  din1;
    logic        in_signed;
    logic        in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] dout;
    logic        out_ovf;

    typedef struct packed {
        logic [30:0] d;
        logic        o;
    } out_t;

    out_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    norm1_mul_pipe dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .in_signed (in_signed),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_ovf   (out_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    // Record every output handshake; sampled mid-cycle, taken at the next edge.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) q.push_back('{d: dout, o: out_ovf});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [5:0] b,
                        input logic s, input logic acc, input logic last);
        din0 = a; din1 = b; in_signed = s; in_acc = acc; in_last = last;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ap_clk);
            if (in_ready) begin
                @(posedge ap_clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge ap_clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $error("FAIL send_timeout: observed in_ready=0 required 1");
        in_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [30:0] ed, input logic eo);
        out_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed no output required %0d", tag, ed);
        end else begin
            e = q.pop_front();
            chk({tag, "_dout"}, e.d, ed);
            chk({tag, "_ovf"}, e.o, eo);
        end
    endtask

    initial begin
        ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0; in_signed = 1'b0; in_acc = 1'b0; in_last = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        idle(2);
        ap_rst_n = 1'b1;

        // unsigned max x max, latency of three edges
        send(25'h1FFFFFF, 6'h3F, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("lat_early_valid", out_valid, 0);
        idle(1);
        chk("lat_valid", out_valid, 1);
        chk("umax_dout", dout, 2113929153);
        chk("umax_ovf", out_ovf, 0);
        idle(2);
        q.delete();

        // signed -1 x -1
        send(25'h1FFFFFF, 6'h3F, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("sgn_cnt", q.size(), 1);
        pop("sgn", 31'd1, 1'b0);

        // unsigned three-beat packet
        send(25'd10, 6'd3, 1'b0, 1'b1, 1'b0);
        send(25'd20, 6'd3, 1'b0, 1'b1, 1'b0);
        idle(6);
        chk("pkt_noout", q.size(), 0);
        send(25'd30, 6'd3, 1'b0, 1'b1, 1'b1);
        idle(5);
        chk("pkt_cnt", q.size(), 1);
        pop("pkt", 31'd180, 1'b0);

        // accumulator wrap sets the sticky flag, then a clean one-beat packet
        send(25'h1FFFFFF, 6'h3F, 1'b0, 1'b1, 1'b0);
        send(25'h1FFFFFF, 6'h3F, 1'b0, 1'b1, 1'b1);
        idle(6);
        pop("wrap", 31'd2080374658, 1'b1);
        send(25'd2, 6'd2, 1'b0, 1'b1, 1'b1);
        idle(5);
        chk("one_cnt", q.size(), 1);
        pop("one", 31'd4, 1'b0);

        // plain beat in the middle of a packet
        send(25'd3, 6'd3, 1'b0, 1'b1, 1'b0);
        send(25'd4, 6'd4, 1'b0, 1'b0, 1'b0);
        send(25'd5, 6'd5, 1'b0, 1'b1, 1'b1);
        idle(6);
        chk("mid_cnt", q.size(), 2);
        pop("mid_plain", 31'd16, 1'b0);
        pop("mid_pkt", 31'd34, 1'b0);

        // back-pressure: four beats stall behind a held output
        out_ready = 1'b0;
        send(25'd1, 6'd1, 1'b0, 1'b0, 1'b0);
        send(25'd2, 6'd2, 1'b0, 1'b0, 1'b0);
        send(25'd3, 6'd3, 1'b0, 1'b0, 1'b0);
        send(25'd4, 6'd4, 1'b0, 1'b0, 1'b0);
        chk("stall_first", dout, 1);
        for (int c = 0; c < 5; c++) begin
            idle(1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_dout", dout, 1);
        end
        out_ready = 1'b1;
        idle(8);
        chk("stall_cnt", q.size(), 4);
        pop("stall0", 31'd1, 1'b0);
        pop("stall1", 31'd4, 1'b0);
        pop("stall2", 31'd9, 1'b0);
        pop("stall3", 31'd16, 1'b0);

        // reset in the middle of a packet
        send(25'd1, 6'd1, 1'b0, 1'b1, 1'b0);
        send(25'd2, 6'd2, 1'b0, 1'b1, 1'b0);
        idle(5);
        #3;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ovf", out_ovf, 0);
        chk("arst_in_ready", in_ready, 1);
        din0 = 25'd7; din1 = 6'd7; in_acc = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        send(25'd5, 6'd5, 1'b0, 1'b1, 1'b1);
        idle(6);
        chk("post_rst_cnt", q.size(), 1);
        pop("post_rst", 31'd25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/norm1_mul_pipe.md
NORM1_MUL_PIPE -- requirements
Module: norm1_mul_pipe

Interface
REQ-001 The block SHALL have parameter DIN0_WIDTH, default 25: width of operand din0.
REQ-002 The block SHALL have parameter DIN1_WIDTH, default 6: width of operand din1.
REQ-003 The block SHALL have parameter DOUT_WIDTH, default 31: width of the result and of the accumulator.
REQ-004 The block SHALL have parameter NUM_STAGE, default 3, legal range 1..8: number of pipeline register stages.
REQ-005 The block SHALL have port ap_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-009 The block SHALL have port din0, input, DIN0_WIDTH bits: operand 0.
REQ-010 The block SHALL have port din1, input, DIN1_WIDTH bits: operand 1.
REQ-011 The block SHALL have port in_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; applies per beat.
REQ-012 The block SHALL have port in_acc, input, 1 bit: 1 = beat belongs to an accumulate packet.
REQ-013 The block SHALL have port in_last, input, 1 bit: final beat of an accumulate packet; ignored when in_acc=0.
REQ-014 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-016 The block SHALL have port dout, output, DOUT_WIDTH bits: product or accumulated sum.
REQ-017 The block SHALL have port out_ovf, output, 1 bit: overflow flag qualified by out_valid.

Function
REQ-018 A beat SHALL be accepted on any rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal NOT(out_valid AND NOT out_ready); a stall freezes every pipeline stage, the accumulator, and dout/out_ovf/out_valid.
REQ-020 Full product SHALL be DIN0_WIDTH+DIN1_WIDTH bits: both operands sign-extended when in_signed=1, zero-extended when 0.
REQ-021 If DOUT_WIDTH is at least the full product width, the result SHALL be the product extended per mode; otherwise it SHALL be the low DOUT_WIDTH bits, and the beat's ovf SHALL be 1 when the discarded bits are not a pure sign (signed) or zero (unsigned) extension.
REQ-022 A non-accumulate beat accepted at edge t SHALL present out_valid=1 with its result from edge t+NUM_STAGE, absent stalls.
REQ-023 Accumulate beats SHALL add their DOUT_WIDTH result into the accumulator in the final stage, using modulo 2^DOUT_WIDTH wrap-around.
REQ-024 The packet ovf SHALL be sticky: the OR of per-beat ovf and of any accumulator overflow, judged signed or unsigned per that beat's in_signed.
REQ-025 Accumulate beats with in_last=0 SHALL produce no output.
REQ-026 The in_last beat SHALL output the accumulator including its own contribution, then clear the accumulator and the sticky flag to 0 in the same edge.
REQ-027 A one-beat packet (in_acc=1, in_last=1) SHALL output exactly its own product.
REQ-028 A non-accumulate beat arriving mid-packet SHALL output its own product and SHALL leave the accumulator unchanged.
REQ-029 Outputs SHALL leave the block in acceptance order, with no drop or duplication under any out_ready pattern.
REQ-030 dout and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-031 ap_rst_n=0 SHALL immediately clear out_valid=0, dout=0, out_ovf=0, all stage valids, the accumulator and the sticky flag, independent of ap_clk.
REQ-032 While ap_rst_n=0, in_ready SHALL be 1 but no beat SHALL be accepted.
REQ-033 Reset mid-packet SHALL discard the partial accumulation, and the first post-reset accumulate beat SHALL start a new packet.

Verification (default parameters)
REQ-034 Test: unsigned din0=0x1FFFFFF, din1=0x3F -> after 3 cycles, dout=2113929153 and out_ovf=0.
REQ-035 Test: signed din0=0x1FFFFFF (-1), din1=0x3F (-1) -> dout=1 and out_ovf=0.
REQ-036 Test: unsigned accumulate packet (10,3), (20,3), (30,3 with last) -> a single output dout=180 and out_ovf=0; no output for the first two beats.
REQ-037 Test: unsigned packet of two beats (0x1FFFFFF,0x3F), second with last -> dout=2080374658 and out_ovf=1; a following one-beat packet (2,2) -> dout=4, out_ovf=0.
REQ-038 Test: back-to-back beats with out_ready=0 for 5 cycles -> in_ready=0, dout held constant, and all results delivered in order once out_ready=1.
REQ-039 Test: ap_rst_n pulsed low after beat 2 of an accumulate packet -> outputs cleared at once, and a new packet (5,5 with last) -> dout=25.
